// File: rtl/handshake_sync_arbiter.sv
// handshake_sync_arbiter
//   Shares one handshake_synchronizer source port among NUM_REQ requesters in
//   the src_clk domain. A round-robin winner is picked only while idle, exactly
//   one transfer is launched for it, and the arbiter waits for the synchronizer
//   to leave idle and come back before arbitrating again.
//
// Ports
//   src_clk, src_reset    source clock, asynchronous active-high reset
//   req[NUM_REQ]          level requests; hold req and data until gnt
//   req_data              payload slice i = req_data[i*DATA_WIDTH +: DATA_WIDTH]
//   gnt[NUM_REQ]          one-hot pulse on the cycle the payload is accepted
//   start, data_in        to synchronizer source port
//   ready                 from synchronizer, high while its sender is idle
//   busy                  high from winner selection until transfer completes
//   owner                 index of current / last winner
//   xfer_count            completed transfers, wraps silently
module handshake_sync_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                          src_clk,
    input  logic                          src_reset,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            gnt,
    output logic                          start,
    output logic [DATA_WIDTH-1:0]         data_in,
    input  logic                          ready,
    output logic                          busy,
    output logic [$clog2(NUM_REQ)-1:0]    owner,
    output logic [CNT_WIDTH-1:0]          xfer_count
);
    localparam int OW = $clog2(NUM_REQ);

    typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_LOW, WAIT_HIGH} state_t;

    state_t                state, state_nxt;
    logic [OW-1:0]         rr_ptr;
    logic [OW-1:0]         win_idx;
    logic                  win_found;
    logic [DATA_WIDTH-1:0] win_data;
    logic [OW:0]           scan;
    logic [OW-1:0]         owner_inc;
    logic                  select, done;

    // Round-robin scan: first set request at rr_ptr, rr_ptr+1, ... mod NUM_REQ.
    // One extra bit holds rr_ptr+i before folding back into range.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        scan      = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            scan = {1'b0, rr_ptr} + (OW+1)'(i);
            if (scan >= (OW+1)'(NUM_REQ))
                scan = scan - (OW+1)'(NUM_REQ);
            if (!win_found && req[scan[OW-1:0]]) begin
                win_found = 1'b1;
                win_idx   = scan[OW-1:0];
            end
        end
    end

    always_comb begin
        win_data = '0;
        for (int i = 0; i < NUM_REQ; i++)
            if (win_idx == OW'(i))
                win_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
    end

    assign owner_inc = (owner == OW'(NUM_REQ-1)) ? '0 : owner + 1'b1;

    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        gnt       = '0;
        select    = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (ready && win_found) begin
                    select    = 1'b1;
                    state_nxt = LAUNCH;
                end
            end
            LAUNCH: begin
                start = 1'b1;
                // start && ready is the accepting cycle; otherwise hold start/data
                if (ready) begin
                    gnt[owner] = 1'b1;
                    state_nxt  = WAIT_LOW;
                end
            end
            WAIT_LOW: begin
                // sender must visibly leave idle before completion can be trusted
                if (!ready)
                    state_nxt = WAIT_HIGH;
            end
            WAIT_HIGH: begin
                if (ready) begin
                    done      = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge src_clk or posedge src_reset) begin
        if (src_reset) begin
            state      <= IDLE;
            rr_ptr     <= '0;
            owner      <= '0;
            data_in    <= '0;
            busy       <= 1'b0;
            xfer_count <= '0;
        end else begin
            state <= state_nxt;
            if (select) begin
                owner   <= win_idx;
                data_in <= win_data;
                busy    <= 1'b1;
            end
            if (done) begin
                xfer_count <= xfer_count + 1'b1;
                rr_ptr     <= owner_inc;
                busy       <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_handshake_sync_arbiter.sv
`timescale 1ns/1ps
module tb_handshake_sync_arbiter;
    localparam int N  = 4;
    localparam int DW = 32;
    localparam int OW = 2;

    logic            src_clk   = 1'b0;
    logic            src_reset = 1'b1;
    logic [N-1:0]    req       = '0;
    logic [N*DW-1:0] req_data  = '0;
    logic            ready     = 1'b1;

    logic [N-1:0]  gnt, gnt_w;
    logic          start, start_w, busy, busy_w;
    logic [DW-1:0] data_in, data_in_w;
    logic [OW-1:0] owner, owner_w;
    logic [15:0]   xfer_count;
    logic [1:0]    xfer_count_w;

    int checks = 0;
    int errors = 0;

    always #5 src_clk = ~src_clk;

    handshake_sync_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .CNT_WIDTH(16)) dut (
        .src_clk(src_clk), .src_reset(src_reset), .req(req), .req_data(req_data),
        .gnt(gnt), .start(start), .data_in(data_in), .ready(ready),
        .busy(busy), .owner(owner), .xfer_count(xfer_count));

    // narrow counter instance, same stimulus, for the wrap behaviour
    handshake_sync_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .CNT_WIDTH(2)) dut_w (
        .src_clk(src_clk), .src_reset(src_reset), .req(req), .req_data(req_data),
        .gnt(gnt_w), .start(start_w), .data_in(data_in_w), .ready(ready),
        .busy(busy_w), .owner(owner_w), .xfer_count(xfer_count_w));

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level reference ----------------
    // A transfer is: selected -> accepted (start&&ready) -> sender seen busy
    // (ready low) -> sender seen idle again (ready high) -> complete.
    bit           m_busy = 0, m_acc = 0, m_left = 0;
    int           m_owner = 0, m_ptr = 0;
    logic [DW-1:0] m_data = '0;
    int unsigned  m_count = 0;
    bit           m_found;
    int           m_c;

    always @(posedge src_clk or posedge src_reset) begin
        if (src_reset) begin
            m_busy = 0; m_acc = 0; m_left = 0;
            m_owner = 0; m_ptr = 0; m_data = '0; m_count = 0;
        end else if (!m_busy) begin
            if (ready && req != '0) begin
                m_found = 0;
                for (int k = 0; k < N; k++) begin
                    m_c = (m_ptr + k) % N;
                    if (!m_found && req[m_c]) begin
                        m_found = 1;
                        m_owner = m_c;
                    end
                end
                m_data = req_data[m_owner*DW +: DW];
                m_busy = 1; m_acc = 0; m_left = 0;
            end
        end else if (!m_acc) begin
            if (ready) m_acc = 1;
        end else if (!m_left) begin
            if (!ready) m_left = 1;
        end else if (ready) begin
            m_count++;
            m_ptr  = (m_owner + 1) % N;
            m_busy = 0;
        end
    end

    bit           e_start;
    logic [N-1:0] e_gnt;

    always @(negedge src_clk) begin
        e_start = m_busy && !m_acc;
        e_gnt   = (e_start && ready) ? (N'(1) << m_owner) : '0;
        chk("start",      64'(start),        64'(e_start));
        chk("gnt",        64'(gnt),          64'(e_gnt));
        chk("busy",       64'(busy),         64'(m_busy));
        chk("owner",      64'(owner),        64'(m_owner));
        chk("data_in",    64'(data_in),      64'(m_data));
        chk("xfer_count", 64'(xfer_count),   64'(m_count[15:0]));
        chk("w_start",    64'(start_w),      64'(e_start));
        chk("w_gnt",      64'(gnt_w),        64'(e_gnt));
        chk("w_count",    64'(xfer_count_w), 64'(m_count[1:0]));
    end

    // ---------------- synchronizer emulation + scoreboard ----------------
    bit            auto_rdy = 1;
    int            low_cnt  = 0;
    int            low_len  = 3;
    logic [DW-1:0] rx_q[$];
    logic [N-1:0]  gnt_q[$];

    task automatic step();
        bit acc;
        @(negedge src_clk);
        acc = start && ready;
        if (acc) begin
            rx_q.push_back(data_in);
            gnt_q.push_back(gnt);
        end
        @(posedge src_clk);
        #1;
        if (auto_rdy) begin
            if (acc) begin
                ready   = 1'b0;
                low_cnt = low_len;
            end else if (low_cnt > 0) begin
                low_cnt--;
                if (low_cnt == 0) ready = 1'b1;
            end
        end
    endtask

    task automatic wait_grants(input int n, input int budget);
        int k = 0;
        do begin
            step();
            k++;
        end while (!(gnt_q.size() >= n && !busy) && k < budget);
        if (!(gnt_q.size() >= n && !busy)) begin
            checks++;
            errors++;
            $display("FAIL wait_grants: actual %0d grants busy=%0b required %0d grants busy=0",
                     gnt_q.size(), busy, n);
        end
    endtask

    logic [1:0]   cnt_seq [8];
    logic [1:0]   exp_wrap [5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    logic [N-1:0] exp_g;

    initial begin
        // ---- reset from power-up ----
        repeat (3) step();
        src_reset = 1'b0;
        chk("rst_start", 64'(start), 64'd0);
        chk("rst_busy",  64'(busy),  64'd0);
        chk("rst_count", 64'(xfer_count), 64'd0);
        step();

        // ---- single requester on slot 2 ----
        req_data[2*DW +: DW] = 32'hDEADBEEF;
        req = 4'b0100;
        step();
        chk("single_start", 64'(start),   64'd1);
        chk("single_data",  64'(data_in), 64'hDEADBEEF);
        chk("single_gnt",   64'(gnt),     64'b0100);
        step();
        chk("single_rdy_low", 64'(ready), 64'd0);
        req = '0;
        wait_grants(1, 40);
        chk("single_count", 64'(xfer_count), 64'd1);
        chk("single_rx",    64'(rx_q[0]),    64'hDEADBEEF);

        // ---- reset in the middle of WAIT_HIGH ----
        rx_q.delete(); gnt_q.delete();
        for (int i = 0; i < N; i++) req_data[i*DW +: DW] = 32'hA000_0000 + 32'(i);
        req = 4'b1111;
        step(); step(); step();
        chk("pre_rst_gnt",  64'(gnt_q[0]), 64'b1000);  // rr_ptr was 3
        chk("pre_rst_busy", 64'(busy),     64'd1);
        src_reset = 1'b1;
        ready = 1'b1; low_cnt = 0;
        #1;
        chk("midrst_start", 64'(start),      64'd0);
        chk("midrst_gnt",   64'(gnt),        64'd0);
        chk("midrst_busy",  64'(busy),       64'd0);
        chk("midrst_count", 64'(xfer_count), 64'd0);
        chk("midrst_owner", 64'(owner),      64'd0);
        step();
        src_reset = 1'b0;
        rx_q.delete(); gnt_q.delete();

        // ---- round-robin, all requesting, 8 transfers ----
        for (int t = 0; t < 8; t++) begin
            wait_grants(t + 1, 40);
            cnt_seq[t] = xfer_count_w;
        end
        req = '0;
        for (int t = 0; t < 8; t++) begin
            exp_g = N'(1) << (t % N);
            chk("rr_gnt",  64'(gnt_q[t]), 64'(exp_g));
            chk("rr_data", 64'(rx_q[t]),  64'(32'hA000_0000 + 32'(t % N)));
        end
        for (int t = 0; t < 5; t++) chk("wrap_count", 64'(cnt_seq[t]), 64'(exp_wrap[t]));
        chk("rr_count", 64'(xfer_count), 64'd8);
        step();

        // ---- ready held low for 5 cycles in LAUNCH ----
        rx_q.delete(); gnt_q.delete();
        auto_rdy = 0;
        req_data[0 +: DW] = 32'h5555AAAA;
        req = 4'b0001;
        step();
        ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step();
            chk("stall_start", 64'(start),   64'd1);
            chk("stall_gnt",   64'(gnt),     64'd0);
            chk("stall_data",  64'(data_in), 64'h5555AAAA);
        end
        ready = 1'b1;
        #1;
        chk("stall_gnt_rise", 64'(gnt), 64'b0001);
        auto_rdy = 1;
        step();
        req = '0;
        wait_grants(1, 40);
        chk("stall_one_launch", 64'(gnt_q.size()), 64'd1);
        chk("stall_rx",         64'(rx_q[0]),      64'h5555AAAA);
        chk("stall_count",      64'(xfer_count),   64'd9);

        // ---- late request during WAIT_HIGH ----
        rx_q.delete(); gnt_q.delete();
        req_data[0 +: DW]  = 32'h1111_0000;
        req_data[DW +: DW] = 32'h2222_0000;
        req = 4'b0001;
        step(); step();
        req = '0;
        step();
        req = 4'b0010;
        for (int k = 0; k < 20 && xfer_count == 16'd9; k++) begin
            chk("late_no_start", 64'(start), 64'd0);
            step();
        end
        chk("late_count", 64'(xfer_count), 64'd10);
        wait_grants(2, 40);
        req = '0;
        chk("late_gnt0", 64'(gnt_q[0]), 64'b0001);
        chk("late_gnt1", 64'(gnt_q[1]), 64'b0010);
        chk("late_rx1",  64'(rx_q[1]),  64'h2222_0000);
        chk("late_end_count", 64'(xfer_count), 64'd11);
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not end, required finish before 200000ns");
        $fatal(1);
    end
endmodule
